// File: rtl/lab3_seq_if.sv
// lab3_seq_if: bundles the sweep handshake, the Lab3 drive/sample pins and the captured table.
// master = controller/stub side, slave = the lab3_seq sequencer.
interface lab3_seq_if;
  logic        start;
  logic        a;
  logic        b;
  logic        c;
  logic        x;
  logic        y;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [2:0]  idx;

  modport master (
    output start, x, y,
    input  a, b, c, busy, done, result, idx
  );

  modport slave (
    input  start, x, y,
    output a, b, c, busy, done, result, idx
  );
endinterface

// File: rtl/lab3_seq.sv
// lab3_seq: walks a 3-input Lab3 circuit through all 8 input vectors and captures {y,x} per vector.
// Define LAB3_CHECK_EN to add the mismatch output comparing the captured table with EXPECT.
module lab3_seq #(
  parameter int unsigned SETTLE = 1,
  parameter logic [15:0] EXPECT = 16'h0000
) (
  input  logic      clk,
  input  logic      rst_n,
  lab3_seq_if.slave bus
`ifdef LAB3_CHECK_EN
  ,
  output logic      mismatch
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    FINISH
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      r_state;
  state_t      w_stateNext;
  logic [2:0]  r_idx;
  logic [2:0]  w_idxNext;
  logic [3:0]  r_settle;
  logic [3:0]  w_settleNext;
  logic [15:0] r_result;
  logic [15:0] w_resultNext;
  logic [2:0]  r_abc;
  logic [2:0]  w_abcNext;
  logic        r_busy;
  logic        w_busyNext;
  logic        r_done;
  logic        w_doneNext;
  logic        w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // busy/done/{a,b,c} are decoded from the next state so they come straight from flops.
  always_comb begin
    w_stateNext  = r_state;
    w_idxNext    = r_idx;
    w_settleNext = r_settle;
    w_resultNext = r_result;
    w_accept     = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_stateNext  = APPLY;
          w_idxNext    = 3'd0;
          w_settleNext = 4'd0;
          w_resultNext = 16'h0000;
        end
      end
      APPLY: begin
        if (r_settle == SETTLE_LAST) begin
          w_stateNext  = SAMPLE;
          w_settleNext = 4'd0;
        end else begin
          w_settleNext = r_settle + 4'd1;
        end
      end
      SAMPLE: begin
        w_resultNext[{r_idx, 1'b0} +: 2] = {bus.y, bus.x};
        if (r_idx == 3'd7) begin
          w_stateNext = FINISH;
        end else begin
          w_idxNext   = r_idx + 3'd1;
          w_stateNext = APPLY;
        end
      end
      FINISH: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase

    w_busyNext = (w_stateNext == APPLY) || (w_stateNext == SAMPLE);
    w_doneNext = (w_stateNext == FINISH);
    w_abcNext  = w_busyNext ? w_idxNext : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= 3'd0;
      r_settle <= 4'd0;
      r_result <= 16'h0000;
      r_abc    <= 3'b000;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_idx    <= w_idxNext;
      r_settle <= w_settleNext;
      r_result <= w_resultNext;
      r_abc    <= w_abcNext;
      r_busy   <= w_busyNext;
      r_done   <= w_doneNext;
    end
  end

  assign bus.a      = r_abc[2];
  assign bus.b      = r_abc[1];
  assign bus.c      = r_abc[0];
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.idx    = r_idx;

`ifdef LAB3_CHECK_EN
  logic r_mismatch;

  // Evaluated on the edge into FINISH, using the table including the final sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch <= 1'b0;
    end else if (w_accept) begin
      r_mismatch <= 1'b0;
    end else if ((r_state == SAMPLE) && (w_stateNext == FINISH)) begin
      r_mismatch <= (w_resultNext != EXPECT);
    end
  end

  assign mismatch = r_mismatch;
`else
  logic w_unusedExpect;
  logic w_unusedAccept;

  assign w_unusedExpect = ^EXPECT;
  assign w_unusedAccept = w_accept;
`endif

endmodule

// File: tb/tb_lab3_seq.sv
// tb_lab3_seq: drives two sequencers (SETTLE=1 and SETTLE=3) against Lab3 stubs and
// checks vector timing, capture, done/busy, restart and reset behaviour against a table model.
module tb_lab3_seq;

  localparam int          SETTLE_A   = 1;
  localparam int          SETTLE_B   = 3;
  localparam logic [15:0] EXPECT_A   = 16'hE994;
  localparam logic [15:0] EXPECT_B   = 16'hE995;
  localparam logic [15:0] STUB_TABLE = 16'hE994;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        startV[2];
  logic        useTable[2];
  logic [15:0] tbl[2];
  logic [15:0] lastResult[2];
  int          checks = 0;
  int          errors = 0;

  lab3_seq_if busA();
  lab3_seq_if busB();

`ifdef LAB3_CHECK_EN
  logic mismatchA;
  logic mismatchB;
  logic obsMis[2];
  logic lastMis[2];
  assign obsMis[0] = mismatchA;
  assign obsMis[1] = mismatchB;
`endif

  lab3_seq #(.SETTLE(SETTLE_A), .EXPECT(EXPECT_A)) dutA (
    .clk(clk),
    .rst_n(rst_n),
    .bus(busA)
`ifdef LAB3_CHECK_EN
    ,
    .mismatch(mismatchA)
`endif
  );

  lab3_seq #(.SETTLE(SETTLE_B), .EXPECT(EXPECT_B)) dutB (
    .clk(clk),
    .rst_n(rst_n),
    .bus(busB)
`ifdef LAB3_CHECK_EN
    ,
    .mismatch(mismatchB)
`endif
  );

  // Lab3 stand-in: either the parity/majority circuit or an arbitrary random truth table.
  function automatic logic [1:0] lab3Out(input logic useTbl, input logic [15:0] t, input logic [2:0] v);
    if (useTbl) return t[2*int'(v) +: 2];
    return {((v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0])), ^v};
  endfunction

  assign busA.start = startV[0];
  assign busB.start = startV[1];
  assign {busA.y, busA.x} = lab3Out(useTable[0], tbl[0], {busA.a, busA.b, busA.c});
  assign {busB.y, busB.x} = lab3Out(useTable[1], tbl[1], {busB.a, busB.b, busB.c});

  logic [2:0]  obsAbc[2];
  logic [2:0]  obsIdx[2];
  logic        obsBusy[2];
  logic        obsDone[2];
  logic [15:0] obsResult[2];
  assign obsAbc[0]    = {busA.a, busA.b, busA.c};
  assign obsAbc[1]    = {busB.a, busB.b, busB.c};
  assign obsIdx[0]    = busA.idx;
  assign obsIdx[1]    = busB.idx;
  assign obsBusy[0]   = busA.busy;
  assign obsBusy[1]   = busB.busy;
  assign obsDone[0]   = busA.done;
  assign obsDone[1]   = busB.done;
  assign obsResult[0] = busA.result;
  assign obsResult[1] = busB.result;

  function automatic int settleOf(input int w);
    return (w == 0) ? SETTLE_A : SETTLE_B;
  endfunction

  function automatic logic [15:0] expectOf(input int w);
    return (w == 0) ? EXPECT_A : EXPECT_B;
  endfunction

  function automatic string tg(input int w, input string name, input int k);
    return $sformatf("dut%0d.%s@%0d", w, name, k);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input int w, input string name);
    checkOutput(tg(w, {name, ".done"}, 0), 32'(obsDone[w]), 32'd0);
    checkOutput(tg(w, {name, ".busy"}, 0), 32'(obsBusy[w]), 32'd0);
    checkOutput(tg(w, {name, ".abc"}, 0), 32'(obsAbc[w]), 32'd0);
    checkOutput(tg(w, {name, ".result"}, 0), 32'(obsResult[w]), 32'(lastResult[w]));
`ifdef LAB3_CHECK_EN
    checkOutput(tg(w, {name, ".mismatch"}, 0), 32'(obsMis[w]), 32'(lastMis[w]));
`endif
  endtask

  // One sweep: vector v is presented during cycles k in [v*s, v*s+s-1] after the accepting edge.
  task automatic applyStimulus(input int w, input bit holdStart, input bit pokeAt3, input int abortK);
    int s;
    int n;
    int v;
    logic [15:0] full;
    logic [15:0] part;
    s    = settleOf(w) + 1;
    n    = 8 * s;
    full = 16'h0000;
    for (int i = 0; i < 8; i++) full[2*i +: 2] = lab3Out(useTable[w], tbl[w], 3'(i));
    startV[w] = 1'b1;
    tick();
    if (!holdStart) startV[w] = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) tick();
      if (abortK == k) begin
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
          checkOutput(tg(d, "rst.abc", k), 32'(obsAbc[d]), 32'd0);
          checkOutput(tg(d, "rst.busy", k), 32'(obsBusy[d]), 32'd0);
          checkOutput(tg(d, "rst.done", k), 32'(obsDone[d]), 32'd0);
          checkOutput(tg(d, "rst.idx", k), 32'(obsIdx[d]), 32'd0);
          checkOutput(tg(d, "rst.result", k), 32'(obsResult[d]), 32'd0);
          lastResult[d] = 16'h0000;
`ifdef LAB3_CHECK_EN
          checkOutput(tg(d, "rst.mismatch", k), 32'(obsMis[d]), 32'd0);
          lastMis[d] = 1'b0;
`endif
        end
        startV[w] = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) begin
          tick();
          checkIdle(w, "postAbort");
        end
        return;
      end
      v    = k / s;
      part = full & 16'((32'd1 << (2*v)) - 32'd1);
      checkOutput(tg(w, "abc", k), 32'(obsAbc[w]), 32'(v));
      checkOutput(tg(w, "idx", k), 32'(obsIdx[w]), 32'(v));
      checkOutput(tg(w, "busy", k), 32'(obsBusy[w]), 32'd1);
      checkOutput(tg(w, "done", k), 32'(obsDone[w]), 32'd0);
      checkOutput(tg(w, "result", k), 32'(obsResult[w]), 32'(part));
`ifdef LAB3_CHECK_EN
      checkOutput(tg(w, "mismatch", k), 32'(obsMis[w]), 32'd0);
`endif
      if (pokeAt3 && k == 3*s) startV[w] = 1'b1;
      if (pokeAt3 && k == 3*s + 1) startV[w] = 1'b0;
    end
    tick();
    checkOutput(tg(w, "fin.done", n), 32'(obsDone[w]), 32'd1);
    checkOutput(tg(w, "fin.busy", n), 32'(obsBusy[w]), 32'd0);
    checkOutput(tg(w, "fin.abc", n), 32'(obsAbc[w]), 32'd0);
    checkOutput(tg(w, "fin.idx", n), 32'(obsIdx[w]), 32'd7);
    checkOutput(tg(w, "fin.result", n), 32'(obsResult[w]), 32'(full));
    lastResult[w] = full;
`ifdef LAB3_CHECK_EN
    lastMis[w] = (full != expectOf(w));
    checkOutput(tg(w, "fin.mismatch", n), 32'(obsMis[w]), 32'(lastMis[w]));
`endif
    tick();
    checkIdle(w, "afterDone");
  endtask

  initial begin
    int w;
    int abortK;
    rst_n         = 1'b0;
    startV[0]     = 1'b0;
    startV[1]     = 1'b0;
    useTable[0]   = 1'b0;
    useTable[1]   = 1'b0;
    tbl[0]        = 16'h0000;
    tbl[1]        = 16'h0000;
    lastResult[0] = 16'h0000;
    lastResult[1] = 16'h0000;
`ifdef LAB3_CHECK_EN
    lastMis[0] = 1'b0;
    lastMis[1] = 1'b0;
`endif
    #3;
    checkIdle(0, "reset");
    checkIdle(1, "reset");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      checkIdle(0, "noStart");
      checkIdle(1, "noStart");
    end

    applyStimulus(0, 1'b0, 1'b0, -1);
    checkOutput("dut0.stubTable", 32'(obsResult[0]), 32'(STUB_TABLE));
    applyStimulus(1, 1'b0, 1'b0, -1);
    checkOutput("dut1.stubTable", 32'(obsResult[1]), 32'(STUB_TABLE));

    applyStimulus(0, 1'b0, 1'b1, -1);
    applyStimulus(1, 1'b0, 1'b1, -1);

    applyStimulus(0, 1'b0, 1'b0, 5 * (SETTLE_A + 1));
    applyStimulus(0, 1'b0, 1'b0, -1);
    checkOutput("dut0.afterAbortTable", 32'(obsResult[0]), 32'(STUB_TABLE));

    applyStimulus(1, 1'b1, 1'b0, -1);
    applyStimulus(1, 1'b1, 1'b0, -1);
    applyStimulus(1, 1'b0, 1'b0, -1);

    repeat (24) begin
      w           = int'($urandom_range(0, 1));
      useTable[w] = 1'b1;
      tbl[w]      = 16'($urandom);
      repeat ($urandom_range(0, 3)) begin
        tick();
        checkIdle(w, "gap");
      end
      abortK = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8 * (settleOf(w) + 1) - 1)) : -1;
      applyStimulus(w, 1'b0, 1'($urandom_range(0, 1)), abortK);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lab3_seq.md
LAB3_SEQ -- requirements
Module: lab3_seq

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning wait cycles per vector before sampling (legal range 1..15).
REQ-002 The block SHALL have parameter EXPECT, default 16'h0000, meaning the golden result table; it is used only under LAB3_CHECK_EN.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request one full truth-table sweep; sampled only in IDLE.
REQ-006 a  output  1  Lab3 input a; MSB of current vector index.
REQ-007 b  output  1  Lab3 input b; middle bit of the index.
REQ-008 c  output  1  Lab3 input c; LSB of the index.
REQ-009 x  input  1  Lab3 output x.
REQ-010 y  input  1  Lab3 output y.
REQ-011 busy  output  1  high from start acceptance through the last SAMPLE cycle.
REQ-012 done  output  1  one-cycle pulse when the sweep completes.
REQ-013 result  output  16  captured table; result[2i+1:2i] = {y,x} for vector index i.
REQ-014 idx  output  3  current vector index.

Function
REQ-015 The FSM SHALL have states IDLE, APPLY, SAMPLE and FINISH.
REQ-016 In IDLE with start=1, the FSM SHALL go to APPLY on the next edge, with idx=0, result=16'h0000 and busy=1.
REQ-017 In IDLE with start=0, the FSM SHALL hold all registers.
REQ-018 {a,b,c} SHALL equal idx in APPLY and SAMPLE, and SHALL be 3'b000 in IDLE and FINISH; all three are registered outputs.
REQ-019 APPLY SHALL last exactly SETTLE cycles, counted by a 4-bit settle counter, then go to SAMPLE.
REQ-020 SAMPLE SHALL last one cycle and write {y,x} into result[2*idx+1:2*idx] on its closing edge; no other result bits change.
REQ-021 Leaving SAMPLE, the FSM SHALL go to FINISH if idx==7; otherwise idx increments and the FSM returns to APPLY.
REQ-022 idx SHALL never wrap past 7 within a sweep.
REQ-023 FINISH SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-024 If start is accepted on edge E0, done SHALL be high during the cycle following edge E0 + 8*(SETTLE+1).
REQ-025 start SHALL be ignored in APPLY, SAMPLE and FINISH; no queuing.
REQ-026 A start held high continuously SHALL launch a new sweep on the first IDLE edge after FINISH.
REQ-027 result SHALL hold its value after done until the next start is accepted.

Reset
REQ-028 On rst_n=0 the block SHALL asynchronously force: state=IDLE, idx=0, settle counter=0, a=b=c=0, busy=0, done=0, result=16'h0000 (and mismatch=0 when present).
REQ-029 Reset asserted mid-sweep SHALL abort the sweep without a done pulse.
REQ-030 After reset release, the block SHALL require a fresh start to begin a sweep.

Configuration
REQ-031 With macro LAB3_CHECK_EN defined, the block SHALL add output port mismatch (1 bit); in FINISH, mismatch = (result != EXPECT), and it holds until the next start acceptance, which clears it.
REQ-032 With LAB3_CHECK_EN undefined, the mismatch port and its comparison logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset, then pulse start with SETTLE=1 against a Lab3 stub (x=a^b^c, y=majority) -> result=16'hE994, done pulse in cycle 17 after the accepting edge.
REQ-034 SETTLE=3, same stub -> {a,b,c} holds each value 4 cycles, done 33 cycles after acceptance, result=16'hE994.
REQ-035 Pulse start again while busy=1 at idx=3 -> no restart; sweep completes normally with a single done pulse.
REQ-036 Assert rst_n=0 at idx=5 -> a=b=c=0, busy=0, result=0 immediately; no done; a later start gives a full correct sweep.
REQ-037 With LAB3_CHECK_EN and EXPECT=16'hE994 -> mismatch=0 at done; with EXPECT=16'hE995 -> mismatch=1.
REQ-038 Hold start high continuously -> back-to-back sweeps separated by exactly one IDLE cycle after each FINISH.
